// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - MMIO window register offsets and STATUS bit positions
package mmio_pkg;

  // Byte offsets within the 256-byte MMIO window
  localparam logic [7:0] OFF_TX       = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_GPIO     = 8'h08;
  localparam logic [7:0] OFF_CYC_LO   = 8'h0C;
  localparam logic [7:0] OFF_CYC_HI   = 8'h10;
  localparam logic [7:0] OFF_CYC_CTRL = 8'h14;

  // STATUS register bit positions
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/console_fifo.sv
// rtl/console_fifo.sv - byte FIFO feeding the console TX stream
module console_fifo #(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // Full is judged on the registered count, so a same-cycle pop never makes room for a push
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    head     = empty ? 8'h00 : mem_q[rd_ptr_q];
    count    = count_q;
  end

  // Byte storage; contents need no reset because head is masked while empty
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_dmem.sv
// rtl/mmio_dmem.sv - data RAM plus console/GPIO/cycle-counter MMIO window
module mmio_dmem
  import mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter logic [31:0] IO_BASE    = 32'h0001_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] gpio_out
);

  localparam int RW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram_q [RAM_WORDS];
  logic [31:0]   gpio_q, gpio_d;
  logic          ovf_q, ovf_d;
  logic [63:0]   cyc_q, cyc_d;

  logic          ram_hit, io_hit;
  logic [RW-1:0] ram_idx;
  logic [7:0]    off;
  logic          tx_push, st_wr, gpio_wr, cyc_clr;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic [31:0]   status;

  // Address decode and per-register store strobes
  always_comb begin
    ram_hit = (a[31:RW+2] == '0);
    ram_idx = a[RW+1:2];
    io_hit  = (a[31:8] == IO_BASE[31:8]);
    off     = a[7:0];
    tx_push = we && io_hit && (off == OFF_TX);
    st_wr   = we && io_hit && (off == OFF_STATUS);
    gpio_wr = we && io_hit && (off == OFF_GPIO);
    cyc_clr = we && io_hit && (off == OFF_CYC_CTRL) && wd[0];
  end

  console_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (wd[7:0]),
    .pop       (tx_valid && tx_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Stream outputs come straight from the FIFO head; no bypass from a same-cycle push
  always_comb begin
    tx_valid = !fifo_empty;
    tx_data  = fifo_head;
    gpio_out = gpio_q;
  end

  // Next-state for GPIO, sticky overflow (set beats clear) and the cycle counter (clear beats increment)
  always_comb begin
    gpio_d = gpio_wr ? wd : gpio_q;
    ovf_d  = ovf_q;
    if (st_wr) begin
      ovf_d = 1'b0;
    end
    if (tx_push && fifo_full) begin
      ovf_d = 1'b1;
    end
    cyc_d = cyc_clr ? 64'd0 : cyc_q + 64'd1;
  end

  // Combinational load path: RAM word or MMIO register, zero elsewhere
  always_comb begin
    status                         = '0;
    status[ST_FULL]                = fifo_full;
    status[ST_EMPTY]               = fifo_empty;
    status[ST_OVF]                 = ovf_q;
    status[ST_COUNT_LSB +: CW]     = fifo_count;
    rd = '0;
    if (ram_hit) begin
      rd = ram_q[ram_idx];
    end else if (io_hit) begin
      case (off)
        OFF_STATUS: rd = status;
        OFF_GPIO:   rd = gpio_q;
        OFF_CYC_LO: rd = cyc_q[31:0];
        OFF_CYC_HI: rd = cyc_q[63:32];
        default:    rd = '0;
      endcase
    end
  end

  // Word RAM, full-word stores only; reads in the same cycle see the old word
  always_ff @(posedge clk) begin
    if (we && ram_hit) begin
      ram_q[ram_idx] <= wd;
    end
  end

  // MMIO state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q <= '0;
      ovf_q  <= 1'b0;
      cyc_q  <= '0;
    end else begin
      gpio_q <= gpio_d;
      ovf_q  <= ovf_d;
      cyc_q  <= cyc_d;
    end
  end

endmodule

// File: tb/tb_mmio_dmem.sv
// tb/tb_mmio_dmem.sv - self-checking bench for mmio_dmem
module tb_mmio_dmem;

  localparam logic [31:0] IO = 32'h0001_0000;

  logic        clk, rst, we, tx_ready;
  logic [31:0] a, wd, rd, gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_dmem dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .a        (a),
    .wd       (wd),
    .rd       (rd),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .gpio_out (gpio_out)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_ram [64];
  bit          m_ramv [64];
  logic [7:0]  m_q [$];
  logic [31:0] m_gpio;
  bit          m_ovf;
  logic [63:0] m_cyc;

  typedef struct {
    logic        w;
    logic [31:0] ad;
    logic [31:0] d;
    logic        r;
    bit          chk;
    logic [31:0] erd;
    logic        etv;
    logic [7:0]  etd;
  } vec_t;

  vec_t tbl [$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] m_read(input logic [31:0] addr);
    logic [31:0] st;
    if (addr < 32'd256) return {m_ramv[addr[7:2]], m_ram[addr[7:2]]};
    if (addr[31:8] != IO[31:8]) return {1'b1, 32'h0};
    st = {16'h0, 8'(m_q.size()), 5'b0, m_ovf, m_q.size() == 0, m_q.size() == 8};
    case (addr[7:0])
      8'h04:   return {1'b1, st};
      8'h08:   return {1'b1, m_gpio};
      8'h0C:   return {1'b1, m_cyc[31:0]};
      8'h10:   return {1'b1, m_cyc[63:32]};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic check_model();
    logic [32:0] e;
    e = m_read(a);
    if (e[32]) cmp($sformatf("model_rd@%h", a), rd, e[31:0]);
    cmp("model_tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    cmp("model_tx_data", 32'(tx_data), 32'(m_q.size() != 0 ? m_q[0] : 8'h00));
    cmp("model_gpio", gpio_out, m_gpio);
  endtask

  task automatic m_step();
    bit          io;
    logic [7:0]  off;
    io  = (a[31:8] == IO[31:8]);
    off = a[7:0];
    if (rst) begin
      m_q.delete();
      m_gpio = 0;
      m_ovf  = 0;
      m_cyc  = 0;
    end else begin
      int n = m_q.size();
      if (n > 0 && tx_ready) void'(m_q.pop_front());
      if (we && io && off == 8'h04) m_ovf = 0;
      if (we && io && off == 8'h00) begin
        if (n == 8) m_ovf = 1;
        else m_q.push_back(wd[7:0]);
      end
      if (we && io && off == 8'h08) m_gpio = wd;
      m_cyc = (we && io && off == 8'h14 && wd[0]) ? 64'd0 : m_cyc + 64'd1;
    end
    if (we && a < 32'd256) begin
      m_ram[a[7:2]]  = wd;
      m_ramv[a[7:2]] = 1;
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] ad, input logic [31:0] d, input logic r);
    we = w; a = ad; wd = d; tx_ready = r;
    #2;
  endtask

  task automatic finish_cycle(input bit chk);
    if (chk) check_model();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic w, input logic [31:0] ad, input logic [31:0] d, input logic r);
    drive(w, ad, d, r);
    finish_cycle(1);
  endtask

  initial begin
    logic [31:0] v1, addr;
    clk = 0; rst = 1; we = 0; a = 0; wd = 0; tx_ready = 0;
    @(posedge clk); #1;
    drive(0, 0, 0, 0); finish_cycle(0);
    rst = 0;

    // Reset state
    drive(0, IO + 32'h0C, 0, 0);
    cmp("rst_cyc_lo", rd, 32'h0);
    cmp("rst_tx_valid", 32'(tx_valid), 32'h0);
    cmp("rst_tx_data", 32'(tx_data), 32'h0);
    cmp("rst_gpio", gpio_out, 32'h0);
    finish_cycle(1);
    drive(0, IO + 32'h04, 0, 0);
    cmp("rst_status", rd, 32'h0000_0002);
    finish_cycle(1);

    // Directed vectors: RAM, GPIO, console push/drain, unmapped accesses
    tbl.push_back('{1'b1, 32'h0,       32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00});
    tbl.push_back('{1'b1, 32'h10,      32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00});
    tbl.push_back('{1'b0, 32'h10,      32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 32'h13,      32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00});
    tbl.push_back('{1'b1, IO + 32'h08, 32'h0000_00A5, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00});
    tbl.push_back('{1'b0, IO + 32'h08, 32'h0,         1'b0, 1'b1, 32'h0000_00A5, 1'b0, 8'h00});
    tbl.push_back('{1'b1, IO,          32'h41,        1'b0, 1'b0, 32'h0,         1'b0, 8'h00});
    tbl.push_back('{1'b1, IO,          32'h42,        1'b0, 1'b0, 32'h0,         1'b1, 8'h41});
    tbl.push_back('{1'b1, IO,          32'h43,        1'b0, 1'b0, 32'h0,         1'b1, 8'h41});
    tbl.push_back('{1'b0, IO + 32'h04, 32'h0,         1'b0, 1'b1, 32'h0000_0300, 1'b1, 8'h41});
    tbl.push_back('{1'b0, IO,          32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 8'h41});
    tbl.push_back('{1'b0, IO + 32'h04, 32'h0,         1'b1, 1'b1, 32'h0000_0300, 1'b1, 8'h41});
    tbl.push_back('{1'b0, IO + 32'h04, 32'h0,         1'b1, 1'b1, 32'h0000_0200, 1'b1, 8'h42});
    tbl.push_back('{1'b0, IO + 32'h04, 32'h0,         1'b1, 1'b1, 32'h0000_0100, 1'b1, 8'h43});
    tbl.push_back('{1'b0, IO + 32'h04, 32'h0,         1'b0, 1'b1, 32'h0000_0002, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 32'h8000,    32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 8'h00});
    tbl.push_back('{1'b1, 32'h8000,    32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0,         1'b0, 8'h00});
    tbl.push_back('{1'b0, IO + 32'h08, 32'h0,         1'b0, 1'b1, 32'h0000_00A5, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 32'h0,       32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 32'h10,      32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00});
    tbl.push_back('{1'b0, IO + 32'h04, 32'h0,         1'b0, 1'b1, 32'h0000_0002, 1'b0, 8'h00});
    foreach (tbl[i]) begin
      drive(tbl[i].w, tbl[i].ad, tbl[i].d, tbl[i].r);
      if (tbl[i].chk) cmp($sformatf("tbl%0d_rd", i), rd, tbl[i].erd);
      cmp($sformatf("tbl%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].etv));
      cmp($sformatf("tbl%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].etd));
      finish_cycle(1);
    end

    // Reset mid-operation clears GPIO
    rst = 1;
    drive(0, IO + 32'h08, 0, 0); finish_cycle(0);
    rst = 0;
    cmp("gpio_after_rst", gpio_out, 32'h0);

    // Overflow: nine pushes into an 8-entry FIFO with the sink stalled
    for (int i = 0; i < 9; i++) cycle(1, IO, 32'h50 + i, 0);
    drive(0, IO + 32'h04, 0, 0); cmp("ovf_status", rd, 32'h0000_0805); finish_cycle(1);
    cycle(1, IO + 32'h04, 32'h0, 0);
    drive(0, IO + 32'h04, 0, 0); cmp("ovf_cleared", rd, 32'h0000_0801); finish_cycle(1);
    // A pop in the same cycle does not rescue a push into a full FIFO
    cycle(1, IO, 32'h60, 1);
    drive(0, IO + 32'h04, 0, 0); cmp("full_push_pop", rd, 32'h0000_0704); finish_cycle(1);
    for (int i = 0; i < 3; i++) cycle(0, IO + 32'h08, 0, 1);
    cycle(1, IO + 32'h04, 32'h0, 0);
    drive(0, IO + 32'h04, 0, 0); cmp("count4", rd, 32'h0000_0400); finish_cycle(1);
    cycle(1, IO, 32'h61, 1);
    drive(0, IO + 32'h04, 0, 0); cmp("push_pop_count4", rd, 32'h0000_0400); finish_cycle(1);

    // Cycle counter: increments, clear, low-word carry into high word
    drive(0, IO + 32'h0C, 0, 0); v1 = rd; finish_cycle(1);
    drive(0, IO + 32'h0C, 0, 0); cmp("cyc_inc", rd, v1 + 32'd1); finish_cycle(1);
    cycle(1, IO + 32'h14, 32'h1, 0);
    drive(0, IO + 32'h0C, 0, 0); cmp("cyc_clr_lo", rd, 32'h0); finish_cycle(1);
    drive(0, IO + 32'h10, 0, 0); cmp("cyc_clr_hi", rd, 32'h0); finish_cycle(1);
    force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
    m_cyc = 64'h0000_0000_FFFF_FFFF;
    drive(0, IO + 32'h0C, 0, 0);
    cmp("cyc_lo_max", rd, 32'hFFFF_FFFF);
    release dut.cyc_q;
    finish_cycle(1);
    drive(0, IO + 32'h10, 0, 0); cmp("cyc_hi_wrap", rd, 32'h1); finish_cycle(1);
    drive(0, IO + 32'h0C, 0, 0); cmp("cyc_lo_wrap", rd, 32'h1); finish_cycle(1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 64; i++) cycle(1, 32'(i * 4), $urandom, 0);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       addr = $urandom_range(0, 255);
        1:       addr = IO | 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
        2:       addr = IO | 32'($urandom_range(0, 255));
        default: addr = $urandom;
      endcase
      rst = ($urandom_range(0, 49) == 0);
      drive(1'($urandom_range(0, 1)), addr, $urandom, 1'($urandom_range(0, 1)));
      finish_cycle(1);
      rst = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_dmem.md
Name: mmio_dmem

Overview:
Data-side responder for the single-cycle RISC-V core's load/store port. It replaces the plain data RAM with a word RAM plus a memory-mapped I/O window. The window holds a console TX FIFO drained through a valid/ready stream, a GPIO output register and a 64-bit cycle counter. Reads are combinational so the core keeps single-cycle loads; all state updates occur on the rising edge of clk.

Parameters:
RAM_WORDS, 64, depth of word RAM; power of two.
IO_BASE, 32'h0001_0000, base address of the MMIO window; 256-byte aligned.
FIFO_DEPTH, 8, console FIFO entries; power of two, >= 2.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
we  input  1  store strobe from the core; sampled at the clk edge.
a  input  32  byte address from the core ALU result; bits [1:0] ignored.
wd  input  32  store data.
rd  output  32  load data; combinational from a.
tx_data  output  8  head-of-FIFO byte.
tx_valid  output  1  FIFO not empty.
tx_ready  input  1  sink accepts tx_data when tx_valid && tx_ready at the clk edge.
gpio_out  output  32  GPIO register.

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk. Reset applies mid-operation with no exceptions.
- Values after reset: FIFO empty, tx_valid=0, tx_data=0, gpio_out=0, cycle counter=0, overflow flag=0. RAM contents are not reset.
- Decode:
  - RAM hit: a < 4*RAM_WORDS; word index is a[log2(RAM_WORDS)+1:2].
  - IO hit: a[31:8] == IO_BASE[31:8]; offset is a[7:0].
  - Any other address reads 0; writes to it are ignored.
- RAM: rd = ram[index] combinationally. When we and RAM hit, wd is written at the clk edge, with full-word writes only. A read of the same address in the same cycle returns the old data.
- IO registers by offset:
  - 0x00 TX: a write pushes wd[7:0]; a read returns 0.
  - 0x04 STATUS: bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] count; other bits 0. Any write clears overflow.
  - 0x08 GPIO: read/write; a write updates gpio_out at the edge.
  - 0x0C CYCLE_LO: read-only, counter[31:0].
  - 0x10 CYCLE_HI: read-only, counter[63:32].
  - 0x14 CYCLE_CTRL: a write with wd[0]=1 zeroes the counter; reads return 0.
  - Unlisted offsets read 0; writes to them are ignored.
- Cycle counter:
  - 64-bit, increments by 1 every cycle and wraps from 2^64-1 to 0.
  - Clear has priority over increment: the counter reads 0 in the cycle after the clear write.
  - CYCLE_HI is not snapshotted; software handles carry.
- Console FIFO:
  - Push: we && TX hit. Pop: tx_valid && tx_ready.
  - Push while full: byte dropped, overflow set. A simultaneous pop in that cycle does not rescue the push, because full is evaluated before the pop.
  - Simultaneous push and pop while not full: both happen and count is unchanged.
  - Push into an empty FIFO: tx_valid rises on the next cycle. There is no bypass and latency is 1.
  - tx_data is stable while tx_valid && !tx_ready.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- A STATUS write that clears overflow in the same cycle as an overflowing push leaves overflow=1; set wins.
- No response handshake exists toward the core: loads and stores always complete in one cycle.

Decomposition:
- Package mmio_pkg holds:
  - offsets OFF_TX, OFF_STATUS, OFF_GPIO, OFF_CYC_LO, OFF_CYC_HI, OFF_CYC_CTRL;
  - status bit positions ST_FULL, ST_EMPTY, ST_OVF, ST_COUNT_LSB.
- One sub-module, console_fifo: synchronous FIFO with push/pop, full/empty/count.
- Decode, RAM, GPIO and the counter stay in mmio_dmem.

Test Plan:
- Reset, then a RAM store: we=1, a=0x0000_0010, wd=0xDEADBEEF. Next cycle, a=0x10 gives rd=0xDEADBEEF; a=0x13 also gives 0xDEADBEEF.
- GPIO: write 0x0000_00A5 to IO_BASE+0x08 → gpio_out=0xA5 after the edge; a read returns 0xA5. Assert rst → gpio_out=0 on the next edge.
- Console, with tx_ready=0:
  - Push 0x41, 0x42, 0x43 → STATUS reads count=3, empty=0, tx_data=0x41.
  - Raise tx_ready for 3 cycles → bytes 0x41, 0x42, 0x43 in order, then tx_valid=0 and empty=1.
- Overflow, with tx_ready=0:
  - Push 9 bytes → 9th dropped, STATUS = full|ovf, count=8.
  - Write STATUS → ovf=0.
  - Push plus pop in the same cycle at count 4 → count stays 4.
- Counter:
  - Read CYCLE_LO on two consecutive cycles → values differ by 1.
  - Write 1 to CYCLE_CTRL → the next-cycle read is 0.
  - Force the counter to 0xFFFF_FFFF in the low word → CYCLE_HI increments on wrap.
- Unmapped: a read of 0x0000_8000 → rd=0; a write there leaves RAM, GPIO and the FIFO unchanged.
